rr_mux_nbit: RTL and testbench

- Parametrised, registered N-to-1 mux of W-bit words.
- Each input channel and the output use a valid/ready handshake.
- Two modes: fixed-select, or round-robin arbitration across active channels.
- Sits between the vending datapath sources (coin value, price, change, display words) and shared consumers (display driver, accumulator); replaces ad-hoc 2:1 word muxes.

---
 rtl/rr_mux_nbit_pkg.sv | 17 +
 rtl/rr_mux_nbit_arbiter.sv | 59 +++++
 rtl/rr_mux_nbit.sv | 90 +++++++++
 tb/tb_rr_mux_nbit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_nbit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_nbit_pkg
// Description : Shared definitions for the round-robin N-to-1 word mux:
//               mode encodings and default sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_mux_nbit_pkg;

  localparam logic MODE_FIXED   = 1'b0;
  localparam logic MODE_RR      = 1'b1;

  localparam int   DEF_WIDTH    = 8;
  localparam int   DEF_CHANNELS = 4;

endpackage
`default_nettype wire

// File: rtl/rr_mux_nbit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Rotating-priority arbiter. Requests are rotated so that the
//               pointer channel sits at bit 0, the lowest set bit is found,
//               and its position is mapped back to an absolute index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import rr_mux_nbit_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SELW     = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     ptr,
  input  logic                en,
  output logic [CHANNELS-1:0] grant,
  output logic [SELW-1:0]     grant_idx,
  output logic                any_grant
);

  localparam logic [SELW:0] c_chan = (SELW+1)'(CHANNELS);

  logic [2*CHANNELS-1:0] w_dbl;
  logic [CHANNELS-1:0]   w_rot;
  logic                  w_found;
  logic [SELW:0]         w_k;
  logic [SELW:0]         w_sum;
  logic [SELW:0]         w_abs;

  // Bit k of the rotated vector is req[(ptr + k) mod CHANNELS].
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = CHANNELS'(w_dbl);

  // Lowest set bit of the rotated vector is the nearest request at/after ptr.
  always_comb begin
    w_found = 1'b0;
    w_k     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_k     = (SELW+1)'(k);
      end
    end
  end

  // Map the rotated offset back to an absolute channel index (ptr is always < CHANNELS).
  always_comb begin
    w_sum = {1'b0, ptr} + w_k;
    w_abs = (w_sum >= c_chan) ? (w_sum - c_chan) : w_sum;
  end

  assign any_grant = en && w_found;
  assign grant_idx = SELW'(w_abs);
  assign grant     = any_grant ? (CHANNELS'(1) << grant_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/rr_mux_nbit.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_nbit
// Description : Registered N-to-1 mux of W-bit words with valid/ready on every
//               channel and on the output. Fixed-select or round-robin mode.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_nbit
  import rr_mux_nbit_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SELW     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SELW:0]   c_chan = (SELW+1)'(CHANNELS);
  localparam logic [SELW-1:0] c_last = SELW'(CHANNELS - 1);

  logic [SELW-1:0]     r_ptr;
  logic                w_load;
  logic                w_sel_ok;
  logic [CHANNELS-1:0] w_sel_oh;
  logic [CHANNELS-1:0] w_req;
  logic [SELW-1:0]     w_arb_ptr;
  logic [CHANNELS-1:0] w_grant;
  logic [SELW-1:0]     w_gidx;
  logic                w_any;
  logic [SELW-1:0]     w_ptr_next;

  assign w_load = ~out_valid | out_ready;

  // Fixed mode presents a single request from the selected channel; an
  // out-of-range select produces no request at all, so the output drains.
  always_comb begin
    w_sel_ok  = ({1'b0, sel} < c_chan);
    w_sel_oh  = w_sel_ok ? (CHANNELS'(1) << sel) : '0;
    w_req     = (mode == MODE_RR) ? in_valid : (w_sel_oh & in_valid);
    w_arb_ptr = (mode == MODE_RR) ? r_ptr : '0;
  end

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SELW     (SELW)
  ) u_arb (
    .req       (w_req),
    .ptr       (w_arb_ptr),
    .en        (rst_n),
    .grant     (w_grant),
    .grant_idx (w_gidx),
    .any_grant (w_any)
  );

  assign in_ready   = w_grant & {CHANNELS{w_load}};
  assign w_ptr_next = (w_gidx == c_last) ? '0 : (w_gidx + SELW'(1));

  // Output register and round-robin pointer; pointer only advances in RR mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      r_ptr     <= '0;
    end else if (w_load) begin
      if (w_any) begin
        out_data  <= in_data[w_gidx*WIDTH +: WIDTH];
        out_chan  <= w_gidx;
        out_valid <= 1'b1;
        if (mode == MODE_RR) begin
          r_ptr <= w_ptr_next;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_nbit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux_nbit
// Description : Directed self-checking bench for rr_mux_nbit (4-channel and
//               3-channel instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_nbit;

  logic        clk;
  logic        rst_n;

  // 4-channel instance
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  // 3-channel instance
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3;

  int n_cmp;
  int n_err;

  rr_mux_nbit #(.WIDTH(8), .CHANNELS(4), .SELW(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  rr_mux_nbit #(.WIDTH(8), .CHANNELS(3), .SELW(2)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .mode      (mode3),
    .sel       (sel3),
    .out_data  (out_data3),
    .out_chan  (out_chan3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    in_data    = {8'h13, 8'h12, 8'h11, 8'h10};
    in_valid   = 4'b0000;
    mode       = 1'b1;
    sel        = 2'd0;
    out_ready  = 1'b1;
    in_data3   = {8'h23, 8'h22, 8'h21};
    in_valid3  = 3'b000;
    mode3      = 1'b1;
    sel3       = 2'd0;
    out_ready3 = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {24'd0, out_data},  32'd0);
    chk("rst_out_chan",  {30'd0, out_chan},  32'd0);
    chk("rst_in_ready",  {28'd0, in_ready},  32'd0);
    rst_n = 1'b1;

    // Round-robin fairness: all valid, two full rotations
    in_valid = 4'b1111;
    #1;
    chk("rr_first_ready", {28'd0, in_ready}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rr_chan_%0d", i), {30'd0, out_chan}, i % 4);
      chk($sformatf("rr_data_%0d", i), {24'd0, out_data}, 32'h10 + (i % 4));
      chk($sformatf("rr_valid_%0d", i), {31'd0, out_valid}, 32'd1);
    end

    // Load 8'h11 from channel 1 only (pointer is 0 -> skips to 1, pointer becomes 2)
    in_valid = 4'b0010;
    step();
    chk("bp_load_data", {24'd0, out_data}, 32'h11);

    // Backpressure: hold for three cycles
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_ready_%0d", i), {28'd0, in_ready}, 32'd0);
      step();
      chk($sformatf("bp_data_%0d", i),  {24'd0, out_data}, 32'h11);
      chk($sformatf("bp_valid_%0d", i), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {28'd0, in_ready}, 32'h4);
    step();
    chk("bp_next_data",  {24'd0, out_data},  32'h12);
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);

    // Sparse requests: pointer is 3; grant ch0 alone to move pointer to 1
    in_valid = 4'b0001;
    step();
    chk("sp_setup_chan", {30'd0, out_chan}, 32'd0);
    in_valid = 4'b1001;
    #1;
    chk("sp_ready_ch3", {28'd0, in_ready}, 32'h8);
    step();
    chk("sp_chan3", {30'd0, out_chan}, 32'd3);
    chk("sp_data3", {24'd0, out_data}, 32'h13);
    chk("sp_ready_ch0", {28'd0, in_ready}, 32'h1);
    step();
    chk("sp_chan0", {30'd0, out_chan}, 32'd0);
    in_valid = 4'b0000;
    step();
    chk("sp_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("sp_drain_data",  {24'd0, out_data},  32'h10);
    chk("sp_drain_chan",  {30'd0, out_chan},  32'd0);

    // Fixed mode, sel=2; pointer (now 1) must not move
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b1111;
    in_data  = {8'h13, 8'h3C, 8'h11, 8'h10};
    #1;
    chk("fx_ready", {28'd0, in_ready}, 32'h4);
    step();
    chk("fx_data",  {24'd0, out_data},  32'h3C);
    chk("fx_chan",  {30'd0, out_chan},  32'd2);
    chk("fx_valid", {31'd0, out_valid}, 32'd1);
    step();
    mode = 1'b1;
    #1;
    chk("fx_ptr_frozen", {28'd0, in_ready}, 32'h2);

    // Asynchronous reset mid-stream with A5 held
    mode      = 1'b0;
    sel       = 2'd0;
    in_data   = {8'h13, 8'h3C, 8'h11, 8'hA5};
    step();
    out_ready = 1'b0;
    chk("ar_pre_data",  {24'd0, out_data},  32'hA5);
    chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid",    {31'd0, out_valid}, 32'd0);
    chk("ar_data",     {24'd0, out_data},  32'd0);
    chk("ar_chan",     {30'd0, out_chan},  32'd0);
    chk("ar_in_ready", {28'd0, in_ready},  32'd0);
    step();
    rst_n     = 1'b1;
    mode      = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("ar_post_ready", {28'd0, in_ready}, 32'h1);
    step();
    chk("ar_post_chan", {30'd0, out_chan}, 32'd0);
    chk("ar_post_data", {24'd0, out_data}, 32'hA5);

    // Illegal select on the 3-channel instance
    in_valid3 = 3'b111;
    #1;
    step();
    chk("il_load_valid", {31'd0, out_valid3}, 32'd1);
    chk("il_load_data",  {24'd0, out_data3},  32'h21);
    mode3 = 1'b0;
    sel3  = 2'd3;
    #1;
    chk("il_ready", {29'd0, in_ready3}, 32'd0);
    step();
    chk("il_valid", {31'd0, out_valid3}, 32'd0);
    chk("il_data",  {24'd0, out_data3},  32'h21);
    chk("il_no_x",  {31'd0, $isunknown(out_data3)}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
